// File: rtl/audio_pkg.sv
// Shared audio definitions used by the synthesizer output path and the I2S transmitter.
//   SAMPLE_WIDTH : width of one mono PCM sample
//   FRAME_BITS   : bits per I2S frame (left + right slots)
//   sample_t     : signed two's-complement sample as produced by the synthesizer
//   frame_t      : one full frame worth of serial data
//   slot_t       : bit-slot index within a frame (0..31)
package audio_pkg;

  localparam int unsigned SAMPLE_WIDTH = 16;
  localparam int unsigned FRAME_BITS   = 32;
  localparam int unsigned SLOT_BITS    = 5;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
  typedef logic [FRAME_BITS-1:0]          frame_t;
  typedef logic [SLOT_BITS-1:0]           slot_t;

  localparam slot_t LAST_SLOT = slot_t'(FRAME_BITS - 1);

  // Word select leads the data by one bit: it reflects the channel of the *next* slot,
  // so it is high for slots 15..30 and low for 31 and 0..14.
  function automatic logic lrclk_for_slot(input slot_t s);
    slot_t nxt;
    nxt = s + slot_t'(1);
    return nxt[SLOT_BITS-1];
  endfunction

  // Mono to stereo: the same sample goes out in the left and the right slot.
  function automatic frame_t dup_sample(input sample_t s);
    return {s, s};
  endfunction

endpackage

// File: rtl/bclk_divider.sv
// Bit-clock generator for the I2S transmitter.
// Counts CLK_DIV system clocks per BCLK half-period and toggles bclk on each wrap.
//   clk     : system clock
//   reset_n : synchronous active-low reset (bclk low, counter 0)
//   bclk    : registered bit-clock level
//   rise    : high during the clk cycle whose closing edge drives bclk 0->1
//   fall    : high during the clk cycle whose closing edge drives bclk 1->0
// The strobes are combinational so that logic clocked on the same edge as the toggle
// changes in lock-step with bclk itself.
module bclk_divider #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset_n,
  output logic bclk,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("bclk_divider: CLK_DIV must be at least 2");
  end

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bclk_q, bclk_d;
  logic            wrap;

  assign wrap = (cnt_q == CntMax);

  always_comb begin
    cnt_d  = cnt_q + CntW'(1);
    bclk_d = bclk_q;
    if (wrap) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk = bclk_q;
  assign rise = wrap & ~bclk_q;
  assign fall = wrap & bclk_q;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S (Philips) transmitter for a 16-bit mono sample stream.
// Each accepted sample is sent in both the left and the right slot of one 32-bit frame.
// A one-deep holding register decouples the producer; when no fresh sample is waiting
// at a frame boundary the previous sample is repeated and underrun pulses.
//   clk          : system clock, all logic on the rising edge
//   reset_n      : synchronous active-low reset
//   sample       : signed sample from the synthesizer
//   sample_valid : sample present
//   sample_ready : holding register empty; a transfer happens on valid & ready
//   frame_start  : one-cycle pulse on every frame load
//   underrun     : one-cycle pulse when a frame loads with the holding register empty
//   i2s_bclk     : bit clock, 2*CLK_DIV clk period
//   i2s_lrclk    : word select, 0 = left, 1 = right
//   i2s_sdata    : serial data, MSB first, changes on bclk falling edges
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    frame_start,
  output logic                    underrun,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_sdata
);

  logic fall;
  logic unused_rise;

  bclk_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_bclk_divider (
    .clk    (clk),
    .reset_n(reset_n),
    .bclk   (i2s_bclk),
    .rise   (unused_rise),
    .fall   (fall)
  );

  slot_t   slot_q, slot_d;
  frame_t  shift_q, shift_d;
  sample_t hold_q, hold_d;
  sample_t last_q, last_d;
  logic    hold_full_q, hold_full_d;
  logic    lrclk_q, lrclk_d;
  logic    frame_start_q, frame_start_d;
  logic    underrun_q, underrun_d;

  logic accept;
  logic load;
  logic release_hold;

  assign accept = sample_valid & ~hold_full_q;
  // Frame boundary: the fall event that moves the slot counter from 31 back to 0.
  assign load   = fall & (slot_q == LAST_SLOT);
  // The consumed sample stays marked as held through the frame_start cycle, so ready
  // comes back one cycle after frame_start. An underrun load consumed nothing, and a
  // sample accepted on that very edge must stay put for the next frame.
  assign release_hold = frame_start_q & ~underrun_q;

  always_comb begin
    slot_d        = slot_q;
    lrclk_d       = lrclk_q;
    shift_d       = shift_q;
    last_d        = last_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    frame_start_d = load;
    underrun_d    = load & ~hold_full_q;

    if (fall) begin
      slot_d  = slot_q + slot_t'(1);
      lrclk_d = lrclk_for_slot(slot_d);
      if (load) begin
        // Load decides on the hold state before this edge; no bypass of a same-cycle accept.
        shift_d = dup_sample(hold_full_q ? hold_q : last_q);
      end else begin
        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
      end
    end

    if (load && hold_full_q) begin
      last_d = hold_q;
    end

    if (release_hold) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
      hold_d      = sample_t'(sample);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_q        <= LAST_SLOT;
      lrclk_q       <= 1'b0;
      shift_q       <= '0;
      last_q        <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      lrclk_q       <= lrclk_d;
      shift_q       <= shift_d;
      last_q        <= last_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sample_ready = ~hold_full_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;
  assign i2s_lrclk    = lrclk_q;
  assign i2s_sdata    = shift_q[FRAME_BITS-1];

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Consumes the 16-bit mono sample stream from the synthesizer and serialises it to an external audio DAC as standard I2S (Philips) frames. It sits between the synthesizer output and the board's DAC pins. It generates BCLK, LRCLK and SDATA from the system clock, duplicates each mono sample into the left and right slots, and uses a one-deep holding register with a valid/ready handshake. Underruns repeat the last sample and are flagged.

## Interface
- CLK_DIV, 8: system clocks per BCLK half-period; legal range ≥2. At 24 MHz the default gives BCLK 1.5 MHz and a 46.875 kHz frame rate.
- clk  in  1  system clock (24 MHz); all logic on rising edge
- reset_n  in  1  one clock; reset is synchronous and active-low
- sample  in  16  signed two's-complement sample
- sample_valid  in  1  sample present
- sample_ready  out  1  holding register empty; transfer occurs when valid & ready
- frame_start  out  1  one-cycle pulse when a new frame is loaded
- underrun  out  1  one-cycle pulse when a frame loads with the holding register empty
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select; 0 = left, 1 = right
- i2s_sdata  out  1  serial data, MSB first

## Operation
- Divider counter runs 0..CLK_DIV-1. On wrap, bclk toggles:
  - 0→1 toggle is a rise event.
  - 1→0 toggle is a fall event.
- All serial outputs update only on fall events.
- Slot counter (5 bits) runs 0..31 and increments mod 32 on each fall event.
- Slot mapping:
  - Slots 0–15 carry the left channel.
  - Slots 16–31 carry the right channel.
  - MSB is sent in slots 0 and 16.
- lrclk for slot s is 1 iff ((s+1) mod 32) ≥ 16. It goes high in slot 15 and low in slot 31, one BCLK before each MSB (I2S framing).
- Frame load happens on the fall event where the slot counter wraps 31→0:
  - If the holding register is full, shift_reg := {hold, hold}; last_sample := hold; hold is marked empty.
  - If the holding register is empty, shift_reg := {last_sample, last_sample} and underrun pulses.
  - frame_start pulses on every load.
- On every other fall event, shift_reg shifts left by one. sdata = shift_reg[31].
- Handshake:
  - sample_ready = hold empty.
  - On valid & ready the sample is captured and ready drops the next cycle.
  - ready returns high the cycle after frame_start.
  - At most one sample is consumed per frame.
- Simultaneous accept and load while hold is empty: the load sees empty, so underrun=1 and last_sample is used. The accepted sample stays in hold for the next frame. There is no bypass path.
- Reset values:
  - bclk=0, lrclk=0, sdata=0.
  - Slot counter=31, divider=0.
  - shift_reg=0, last_sample=0, hold empty.
  - sample_ready=1, frame_start=0, underrun=0.
- Reset asserted mid-frame: every register returns to its reset value on the next edge, and a held sample is discarded.

## Timing
- First rise event occurs CLK_DIV cycles after reset release.
- First fall event, and therefore the first frame load, occurs 2·CLK_DIV cycles after reset release.
- BCLK period is 2·CLK_DIV clks. A frame is 64·CLK_DIV clks.
- The bit driven on a fall event is stable through the following rise event, where the DAC samples it.
- frame_start, underrun and the new sdata MSB all appear on the same clk edge as the load fall event.
- Latency from accept to MSB on sdata: at most one frame plus 0 cycles, i.e. the next load.

## Structure
- Shared package audio_pkg:
  - SAMPLE_WIDTH=16
  - FRAME_BITS=32
  - typedef logic signed [15:0] sample_t, also used by the synthesizer output
- Sub-module bclk_divider (CLK_DIV):
  - Outputs the bclk level and single-cycle rise/fall strobes.
  - Has its own reset_n.
- The top level holds the slot counter, holding register, shift register and handshake.

## Test plan
All scenarios use CLK_DIV=2: BCLK period 4 clks, frame 128 clks.
1. Reset, then idle, no valid:
   - During reset, outputs hold their reset values.
   - First frame_start at cycle 4 after release, with underrun=1.
   - sdata=0 for the whole frame; lrclk rises at slot 15 and falls at slot 31.
2. Push 16'hA5C3 at cycle 1:
   - ready drops at cycle 2.
   - At the next load, sdata slots 0–15 = 1010010111000011 and slots 16–31 are identical.
   - ready rises 1 cycle after frame_start.
3. Push 16'h8001 once, then stall valid:
   - Each subsequent frame gives underrun=1 and repeats 8001 in both channels.
4. valid held high with incrementing data 1, 2, 3:
   - Exactly one sample is accepted per frame.
   - Each frame carries the next value with no skips or duplicates.
5. Hold empty, valid asserted on the exact load cycle:
   - underrun=1 and the frame carries the old last_sample.
   - The new sample appears in the following frame.
6. reset_n low for one cycle in slot 10 with hold full:
   - Next cycle all outputs equal their reset values and ready=1.
   - The held sample is never transmitted.
